// File: rtl/exe_arbiter.sv
// Two-requester arbiter in front of a shared execution unit: grants one requester,
// holds its operands for EXEC_CYCLES cycles, then captures the unit's result/flags.
// Optional macro EXE_ARB_FIXED_PRIO_EN: requester 0 always wins a tie (default build is round-robin).
module exe_arbiter #(
  parameter int M           = 8,
  parameter int N           = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic         i_clk_p,
  input  logic         i_rst_n,
  input  logic [1:0]   i_req,
  input  logic [M-1:0] i_argA0,
  input  logic [M-1:0] i_argB0,
  input  logic [M-1:0] i_argA1,
  input  logic [M-1:0] i_argB1,
  input  logic [N-1:0] i_oper0,
  input  logic [N-1:0] i_oper1,
  output logic [1:0]   o_gnt,
  output logic [1:0]   o_done,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_flags,
  output logic         o_busy,
  output logic [M-1:0] o_argA,
  output logic [M-1:0] o_argB,
  output logic [N-1:0] o_oper,
  input  logic [M-1:0] i_result,
  input  logic [3:0]   i_flags
);

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [1:0]     gnt_q, gnt_d;
  logic [1:0]     done_q, done_d;
  logic           busy_q, busy_d;
  logic [M-1:0]   result_q, result_d;
  logic [3:0]     flags_q, flags_d;
  logic [M-1:0]   arga_q, arga_d;
  logic [M-1:0]   argb_q, argb_d;
  logic [N-1:0]   oper_q, oper_d;
  logic           win_s;

  // Winner selection and next-state / next-output computation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    result_d = result_q;
    flags_d  = flags_q;
    arga_d   = arga_q;
    argb_d   = argb_q;
    oper_d   = oper_q;
    win_s    = 1'b0;

    if (i_req == 2'b11) begin
`ifdef EXE_ARB_FIXED_PRIO_EN
      win_s = 1'b0;
`else
      win_s = ~last_q;
`endif
    end else begin
      win_s = i_req[1] & ~i_req[0];
    end

    case (state_q)
      IDLE: begin
        if (i_req != 2'b00) begin
          owner_d = win_s;
          arga_d  = win_s ? i_argA1 : i_argA0;
          argb_d  = win_s ? i_argB1 : i_argB0;
          oper_d  = win_s ? i_oper1 : i_oper0;
          gnt_d   = win_s ? 2'b10 : 2'b01;
          cnt_d   = CNT_LOAD;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d = i_result;
          flags_d  = i_flags;
          done_d   = owner_q ? 2'b10 : 2'b01;
          state_d  = DONE;
        end
      end
      DONE: begin
        // Release only once the served requester drops its level request
        if (!i_req[owner_q]) begin
          gnt_d   = 2'b00;
          done_d  = 2'b00;
          last_d  = owner_q;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      busy_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= 4'b0000;
      arga_q   <= '0;
      argb_q   <= '0;
      oper_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      arga_q   <= arga_d;
      argb_q   <= argb_d;
      oper_q   <= oper_d;
    end
  end

  assign o_gnt    = gnt_q;
  assign o_done   = done_q;
  assign o_busy   = busy_q;
  assign o_result = result_q;
  assign o_flags  = flags_q;
  assign o_argA   = arga_q;
  assign o_argB   = argb_q;
  assign o_oper   = oper_q;

endmodule
